// File: rtl/pid_gen_pkg.sv
// Shared types and saturation helpers for the pid_gen drive controller.
package pid_gen_pkg;

    typedef enum logic [1:0] {PID_P, PID_PI, PID_PD, PID_PID} pid_mode_e;

    function automatic logic mode_has_i(input pid_mode_e m);
        return (m == PID_PI) || (m == PID_PID);
    endfunction

    function automatic logic mode_has_d(input pid_mode_e m);
        return (m == PID_PD) || (m == PID_PID);
    endfunction

    // Clamp to [0, hi]; callers narrow the result with a size cast.
    function automatic logic signed [31:0] sat_u(input logic signed [31:0] v,
                                                 input logic signed [31:0] hi);
        if (v < 0)
            return 32'sd0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    function automatic logic signed [31:0] sat_s(input logic signed [31:0] v,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/pid_gen_dly_line.sv
// Enable-gated shift register; o_q is the value DEPTH accepted updates back.
module pid_dly_line #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr[0] <= i_d;
            for (int k = 1; k < DEPTH; k++)
                r_sr[k] <= r_sr[k-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/pid_gen.sv
// Two-stage PID drive-magnitude generator: stage 1 registers the sample,
// stage 2 registers the saturated P+I+D sum and updates integrator/history.
module pid_gen
    import pid_gen_pkg::*;
#(
    parameter int ERR_W   = 13,
    parameter int OUT_W   = 12,
    parameter int INT_W   = 18,
    parameter int I_SHIFT = 6,
    parameter int D_DEPTH = 2,
    parameter int D_SHIFT = 2,
    parameter int DECIM   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ERR_W-1:0] error,
    input  logic                    err_vld,
    input  logic                    not_pedaling,
    input  logic [1:0]              mode,
    output logic [OUT_W-1:0]        drv_mag,
    output logic                    drv_vld
);

    localparam int SUM_W = ERR_W + 2;
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [31:0] OUT_MAX = 32'sd2 ** OUT_W - 32'sd1;
    localparam logic signed [31:0] INT_MAX = 32'sd2 ** (INT_W - 1) - 32'sd1;
    localparam logic signed [31:0] D_MAX   = 32'sd2 ** (ERR_W - 1) - 32'sd1;
    localparam logic signed [31:0] D_MIN   = -(32'sd2 ** (ERR_W - 1));

    logic [CNT_W-1:0]        r_cnt;
    logic                    w_hit;
    logic signed [ERR_W-1:0] r_err_q;
    pid_mode_e               r_mode_q;
    logic                    r_hit_q;
    logic                    r_np_q;
    logic                    r_v1;
    logic [INT_W-1:0]        r_integ;
    logic [ERR_W-1:0]        w_hist;

    logic signed [31:0]      w_p;
    logic signed [31:0]      w_i;
    logic signed [31:0]      w_d;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [31:0]      w_sum_x;
    logic                    w_frozen;
    logic [OUT_W-1:0]        w_mag;
    logic [INT_W-1:0]        w_int_nxt;

    assign w_hit = err_vld && (r_cnt == CNT_W'(DECIM - 1));

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (err_vld)
            r_cnt <= (r_cnt == CNT_W'(DECIM - 1)) ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_err_q  <= '0;
            r_mode_q <= PID_P;
            r_hit_q  <= 1'b0;
            r_np_q   <= 1'b0;
        end else begin
            r_v1 <= err_vld;
            if (err_vld) begin
                r_err_q  <= error;
                r_mode_q <= pid_mode_e'(mode);
                r_hit_q  <= w_hit;
                r_np_q   <= not_pedaling;
            end
        end
    end

    // Terms are formed at 32 bits, then the sum is wrapped to SUM_W bits.
    assign w_p     = 32'(r_err_q);
    assign w_i     = mode_has_i(r_mode_q) ? $signed(32'(r_integ >> I_SHIFT)) : 32'sd0;
    assign w_d     = mode_has_d(r_mode_q)
                   ? sat_s((w_p - 32'($signed(w_hist))) <<< D_SHIFT, D_MIN, D_MAX)
                   : 32'sd0;
    assign w_sum   = SUM_W'(w_p + w_i + w_d);
    assign w_sum_x = 32'(w_sum);

    assign w_frozen  = (w_sum_x > OUT_MAX) && (w_p > 0);
    assign w_mag     = r_np_q ? '0 : OUT_W'(sat_u(w_sum_x, OUT_MAX));
    assign w_int_nxt = INT_W'(sat_u($signed(32'(r_integ)) + w_p, INT_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            drv_mag <= '0;
            drv_vld <= 1'b0;
        end else begin
            drv_vld <= r_v1;
            if (r_v1)
                drv_mag <= w_mag;
        end
    end

    // not_pedaling clears on every edge, not only when a sample retires.
    always_ff @(posedge clk) begin
        if (rst || not_pedaling)
            r_integ <= '0;
        else if (r_v1) begin
            if (r_np_q || !mode_has_i(r_mode_q))
                r_integ <= '0;
            else if (r_hit_q && !w_frozen)
                r_integ <= w_int_nxt;
        end
    end

    pid_dly_line #(
        .WIDTH (ERR_W),
        .DEPTH (D_DEPTH)
    ) u_hist (
        .clk  (clk),
        .rst  (rst),
        .i_en (r_v1 && r_hit_q),
        .i_d  (r_err_q),
        .o_q  (w_hist)
    );

endmodule

// File: tb/tb_pid_gen.sv
// Directed bench for pid_gen: one DECIM=1 instance and one DECIM=4 instance
// share the stimulus; each test group starts from reset.
module tb_pid_gen;

    logic               clk;
    logic               rst;
    logic signed [12:0] error;
    logic               err_vld;
    logic               not_pedaling;
    logic [1:0]         mode;
    logic [11:0]        drv_mag, drv_mag4;
    logic               drv_vld, drv_vld4;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] M_P = 2'b00, M_PI = 2'b01, M_PD = 2'b10, M_PID = 2'b11;

    pid_gen u_dut (
        .clk          (clk),
        .rst          (rst),
        .error        (error),
        .err_vld      (err_vld),
        .not_pedaling (not_pedaling),
        .mode         (mode),
        .drv_mag      (drv_mag),
        .drv_vld      (drv_vld)
    );

    pid_gen #(.DECIM(4)) u_dec (
        .clk          (clk),
        .rst          (rst),
        .error        (error),
        .err_vld      (err_vld),
        .not_pedaling (not_pedaling),
        .mode         (mode),
        .drv_mag      (drv_mag4),
        .drv_vld      (drv_vld4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst     = 1'b1;
        err_vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Single isolated sample on u_dut; result checked two edges later.
    task automatic one(input int e, input logic [1:0] m, input int exp, input string tag);
        error   = 13'(e);
        mode    = m;
        err_vld = 1'b1;
        tick();
        err_vld = 1'b0;
        chk({tag, "_vld_early"}, 32'(drv_vld), 32'd0);
        tick();
        chk({tag, "_vld"}, 32'(drv_vld), 32'd1);
        chk({tag, "_mag"}, 32'(drv_mag), 32'(exp));
    endtask

    initial begin
        rst          = 1'b0;
        error        = '0;
        err_vld      = 1'b0;
        not_pedaling = 1'b0;
        mode         = M_P;

        do_reset();
        chk("rst_mag", 32'(drv_mag), 32'd0);
        chk("rst_vld", 32'(drv_vld), 32'd0);
        chk("rst_integ", 32'(u_dut.r_integ), 32'd0);

        // P path and latency, then output hold.
        one(500, M_P, 500, "p500");
        tick();
        chk("p500_vld_drop", 32'(drv_vld), 32'd0);
        chk("p500_hold", 32'(drv_mag), 32'd500);
        one(4095, M_P, 4095, "p4095");
        one(-100, M_P, 0, "pneg");

        // Decimation: DECIM=4 streaming, integrator steps on samples 4 and 8.
        do_reset();
        mode  = M_PI;
        error = 13'sd64;
        for (int i = 0; i < 10; i++) begin
            err_vld = (i < 9);
            tick();
            if (i >= 1) begin
                chk($sformatf("dec_vld%0d", i - 1), 32'(drv_vld4), 32'd1);
                chk($sformatf("dec_mag%0d", i - 1), 32'(drv_mag4),
                    (i - 1 < 4) ? 32'd64 : (i - 1 < 8) ? 32'd65 : 32'd66);
            end
        end
        err_vld = 1'b0;
        chk("dec_integ", 32'(u_dec.r_integ), 32'd128);

        // Anti-windup: integrator freezes at 8000 once the sum saturates.
        do_reset();
        one(4000, M_PI, 4000, "aw1");
        one(4000, M_PI, 4062, "aw2");
        one(4000, M_PI, 4095, "aw3");
        one(4000, M_PI, 4095, "aw4");
        one(4000, M_PI, 4095, "aw5");
        chk("aw_integ", 32'(u_dut.r_integ), 32'd8000);
        chk("aw_integ_max", 32'(u_dut.r_integ <= 18'd131071), 32'd1);
        one(0, M_PI, 125, "aw_zero");
        chk("aw_integ_hold", 32'(u_dut.r_integ), 32'd8000);

        // not_pedaling forces zero drive and clears the integrator.
        not_pedaling = 1'b1;
        one(500, M_PI, 0, "np1");
        one(500, M_PI, 0, "np2");
        one(500, M_PI, 0, "np3");
        chk("np_integ", 32'(u_dut.r_integ), 32'd0);
        not_pedaling = 1'b0;
        one(64, M_PI, 64, "np_restart1");
        one(64, M_PI, 65, "np_restart2");
        chk("np_restart_integ", 32'(u_dut.r_integ), 32'd128);

        // Derivative path, including D clamp to +4095 before the sum.
        do_reset();
        one(100, M_PD, 500, "pd1");
        one(100, M_PD, 500, "pd2");
        one(300, M_PD, 1100, "pd3");
        one(-3000, M_PD, 0, "pd4");
        one(-3000, M_PD, 0, "pd5");
        one(-1000, M_PD, 3095, "pd_dclamp");
        chk("pd_integ", 32'(u_dut.r_integ), 32'd0);

        // Full PID: I term uses the pre-update integrator.
        do_reset();
        one(100, M_PID, 500, "pid1");
        one(100, M_PID, 501, "pid2");

        // Reset while a sample sits in stage 1 drops it.
        do_reset();
        error   = 13'sd700;
        mode    = M_P;
        err_vld = 1'b1;
        tick();
        err_vld = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_vld0", 32'(drv_vld), 32'd0);
        tick();
        chk("rst_mid_vld1", 32'(drv_vld), 32'd0);
        tick();
        chk("rst_mid_vld2", 32'(drv_vld), 32'd0);
        chk("rst_mid_mag", 32'(drv_mag), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pid_gen.md
Name: pid_gen

Overview:
- Parametrised successor to the single-channel e-bike PID controller.
- Computes the motor drive magnitude from a signed torque/cadence error sample stream.
- Adds configurable widths, integrator decimation, derivative history depth, runtime P/PI/PD/PID mode select, and integrator anti-windup.
- Sits between the sensor-conditioning block (which supplies error and err_vld) and the PWM/commutation stage (which consumes drv_mag).

Parameters:
- ERR_W, 13: signed error width.
- OUT_W, 12: unsigned drv_mag width.
- INT_W, 18: integrator register width; the integrator holds non-negative values only.
- I_SHIFT, 6: I term = integrator >> I_SHIFT.
- D_DEPTH, 2: derivative compares against the sample D_DEPTH accepted updates back (>=1).
- D_SHIFT, 2: D term = (err - hist) << D_SHIFT, before clamping.
- DECIM, 1: integrator and history update on every DECIM-th err_vld (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- error  in  ERR_W  signed error sample.
- err_vld  in  1  one-cycle sample strobe.
- not_pedaling  in  1  rider idle; clears integrator and forces zero drive.
- mode  in  2  00=P, 01=PI, 10=PD, 11=PID; sampled together with error.
- drv_mag  out  OUT_W  saturated drive magnitude, held between updates.
- drv_vld  out  1  one-cycle pulse when drv_mag updates.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst).
- Reset: drv_mag=0, drv_vld=0, integrator=0, all history entries=0, decimation counter=0, stage-1 valid=0. Reset wins over every other input in the same cycle.
- Decimation counter:
  - Counts err_vld pulses 0..DECIM-1, then wraps.
  - hit = err_vld && (cnt == DECIM-1).
  - With DECIM=1, hit = err_vld.
- Stage 1, at the edge ending a cycle with err_vld=1: capture err_q, mode_q, hit_q, np_q; set v1=1. Otherwise v1=0.
- Stage-1 cycle, combinational terms:
  - P = err_q, sign-extended. Forced 0 in PD mode? No: P is always enabled in every mode.
  - I = integrator >> I_SHIFT, using the pre-update integrator value. Forced 0 if mode_q lacks I.
  - D = clamp((err_q - hist[D_DEPTH-1]) << D_SHIFT, -2^(ERR_W-1), 2^(ERR_W-1)-1). Forced 0 if mode_q lacks D.
  - sum = P + I + D, computed at ERR_W+2 bits signed.
- Stage 2, at the next edge when v1=1:
  - drv_mag <= 0 if np_q, else 0 if sum<0, else 2^OUT_W-1 if sum>2^OUT_W-1, else sum.
  - drv_vld <= 1. drv_vld is 0 in every other cycle.
- Latency: exactly 2 cycles from err_vld to drv_vld. Back-to-back err_vld is accepted every cycle (fully pipelined).
- Integrator update at the stage-2 edge:
  - If np_q or not_pedaling: integrator <= 0.
  - Else if mode_q lacks I: integrator <= 0.
  - Else if hit_q and not frozen: integrator <= clamp(integrator + err_q, 0, 2^(INT_W-1)-1).
  - frozen = (sum > 2^OUT_W-1) && (err_q > 0), i.e. anti-windup on positive saturation.
  - not_pedaling clears the integrator on every edge it is high, even without a sample.
- History: shift register; on hit_q, hist[0] <= err_q and hist[k] <= hist[k-1]. History is not cleared by not_pedaling.
- Simultaneous events: a sample in stage 2 while a new sample enters stage 1 are independent. Stage 1 always sees the integrator/history values before the stage-2 update on the same edge; there is no forwarding.
- Reset asserted mid-pipeline drops any in-flight sample; no drv_vld is issued for it.

Decomposition:
- pid_gen_pkg holds:
  - typedef enum logic [1:0] pid_mode_e {PID_P, PID_PI, PID_PD, PID_PID};
  - functions sat_u (unsigned clamp) and sat_s (signed clamp).
- Sub-module pid_dly_line: a parametrised (WIDTH, DEPTH) enable-gated shift register used for the derivative history.

Test Plan:
- Reset and P path: rst high 2 cycles -> drv_mag=0, drv_vld=0. Then mode=P, error=500, err_vld -> drv_vld pulse exactly 2 cycles later, drv_mag=500.
- P saturation: mode=P, error=4095 -> drv_mag=4095; error=-100 -> drv_mag=0, drv_vld still pulses.
- Integrator with decimation (DECIM=4): mode=PI, error=64 on 8 consecutive cycles.
  - Integrator increments by 64 on samples 4 and 8 only, ending at 128.
  - A 9th sample of 64 gives drv_mag=64+2=66.
- Anti-windup: mode=PI, DECIM=1, error=4000 held.
  - Integrator climbs until sum >4095, then holds that value; drv_mag=4095.
  - Then error=0 -> drv_mag = frozen integrator>>6.
  - Confirm the integrator never exceeds 2^17-1.
- Derivative (DECIM=1, D_DEPTH=2, D_SHIFT=2): mode=PD, errors 100,100,300 -> third output = 300+800 = 1100. A D of 8000 clamps to 4095 before summing.
- not_pedaling mid-run: after the PI ramp, assert not_pedaling for 3 cycles with samples -> drv_mag=0 and integrator=0. Deassert -> accumulation restarts from 0. Also assert rst while a sample is in stage 1 -> no drv_vld.
